// File: rtl/uart_tx_ser_pkg.sv
// Shared constants and state encoding for the 8N1 UART transmit serializer.
package uart_tx_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_BITS);
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_ser_baud_tmr.sv
// Bit-period timer: loadable down-counter that pulses expire_c on its last cycle
// and reloads the divisor captured at the most recent restart.
module uart_baud_tmr #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             run,
  input  logic [DIV_W-1:0] load,
  output logic             expire_c
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] reload_q;

  // reload_q holds the divisor for the whole frame so mid-frame changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else if (restart) begin
      cnt_q    <= load;
      reload_q <= load;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_q <= reload_q;
      end else begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
    end
  end

  assign expire_c = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ser.sv
// 8N1 UART transmit serializer fed from an external first-word-fall-through FIFO.
// Back-to-back frames launch straight from the last stop cycle with no idle gap.
module uart_tx_ser
  import uart_tx_ser_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_r,
  output logic             tx,
  output logic             busy
);

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   shreg_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic                   launch_c;
  logic                   pop_c;
  logic                   expire_c;
  logic                   tx_d;
  logic                   busy_d;

  // Reset gating keeps the pop strobe low while rst is held
  assign launch_c = en && !fifo_empty && !rst;
  assign fifo_r   = pop_c;

  uart_baud_tmr #(
    .DIV_W (DIV_W)
  ) u_baud_tmr (
    .clk      (clk),
    .rst      (rst),
    .restart  (pop_c),
    .run      (state_q != ST_IDLE),
    .load     (baud_div),
    .expire_c (expire_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pop_c     = 1'b0;
    tx_d      = IDLE_LEVEL;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (launch_c) pop_c = 1'b1;
      end
      ST_START: begin
        if (expire_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (expire_c) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (expire_c) begin
          if (launch_c) pop_c = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop, from IDLE or the last stop cycle, always starts a new frame
    if (pop_c) begin
      state_d   = ST_START;
      shreg_d   = fifo_dout;
      bit_cnt_d = '0;
    end

    // Line level is registered from the next state so tx is glitch-free
    case (state_d)
      ST_START: tx_d = ~IDLE_LEVEL;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= IDLE_LEVEL;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_ser.md
UART_TX_SER -- requirements
Module: uart_tx_ser

Interface
REQ-001 SHALL have parameter DIV_W, default 16, setting the width of the baud divisor.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: permits new frames to start.
REQ-005 SHALL have port baud_div, input, DIV_W bits: bit period minus one, in clk cycles.
REQ-006 SHALL have port fifo_dout, input, 8 bits: head word of the upstream first-word-fall-through FIFO.
REQ-007 SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-008 SHALL have port fifo_r, output, 1 bit: one-cycle pop strobe to the upstream FIFO.
REQ-009 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-011 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 SHALL define launch as en=1 and fifo_empty=0 in the same cycle.
REQ-014 SHALL, on launch in IDLE, assert fifo_r combinationally for that cycle only, load fifo_dout into the shift register, capture baud_div, and enter START next cycle.
REQ-015 SHALL never assert fifo_r while fifo_empty=1, nor more than once per frame.
REQ-016 SHALL hold each bit on tx for exactly captured_div+1 cycles; baud_div=0 gives 1 cycle per bit.
REQ-017 SHALL ignore baud_div changes mid-frame; the new value applies from the next launch.
REQ-018 SHALL drive tx as a register: 0 in START, shift-register bit 0 in DATA, 1 in STOP and IDLE.
REQ-019 SHALL move START->DATA at bit-timer expiry.
REQ-020 SHALL, in DATA, shift right at each expiry and move to STOP after the 8th bit via a 3-bit bit counter.
REQ-021 SHALL, at STOP expiry, pop and launch directly into START if launch holds (no idle cycles between frames); otherwise go to IDLE.
REQ-022 SHALL make frame length (10 x (div+1)) cycles from the first START cycle.
REQ-023 SHALL let a frame in progress complete when en falls mid-frame; no new launch occurs while en=0.
REQ-024 SHALL drive busy=1 in START, DATA and STOP, and 0 in IDLE.
REQ-025 SHALL make busy and tx glitch-free registered outputs; fifo_r is the only combinational output.

Reset
REQ-026 SHALL, on rst=1 and independent of clk, set state to IDLE, tx=1, busy=0, fifo_r=0, and clear counters and shift register.
REQ-027 SHALL abort a frame on reset mid-frame and hold tx high immediately; the popped byte is lost.
REQ-028 SHALL permit a launch from the first clk edge after rst deasserts.

Structure
REQ-029 SHALL place in a shared package: state encoding constants, FRAME_BITS=10, DATA_BITS=8, and the IDLE_LEVEL=1 constant.
REQ-030 SHALL contain one sub-module, uart_baud_tmr: a loadable DIV_W down-counter with a one-cycle expiry pulse and a restart input.
REQ-031 SHALL keep the upstream FIFO external; no internal data buffering beyond the one shift register.

Verification
REQ-032 SHALL cover: baud_div=3, single byte 0xA5 -> fifo_r one pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles.
REQ-033 SHALL cover: FIFO holds 0x00, 0xFF, 0x55 with baud_div=0 -> 30 consecutive busy cycles, exactly 3 fifo_r pulses, no idle-high gap between stop and next start.
REQ-034 SHALL cover: en=0 with FIFO non-empty -> fifo_r stays 0 and tx stays 1; en=1 -> launch same cycle; en=0 mid-frame -> frame finishes, no further pop.
REQ-035 SHALL cover: baud_div changed 3->7 during DATA -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-036 SHALL cover: rst pulse during DATA bit 4 -> tx=1, busy=0 asynchronously; after release, next queued byte transmits cleanly.
REQ-037 SHALL check, via a bench assertion, that fifo_r never coincides with fifo_empty=1 and never fires outside IDLE or the last STOP cycle.
